param_mc_proc: RTL

Parametrised multi-cycle processor core: fetch, decode, execute, writeback over a unified internal word memory, plus a register file and a 5-bit program status register. It generalises the 32-bit opcode/cc/src/dest instruction format with a full ISA:
- configurable memory depth and register count
- immediate source operands
- conditional branches
- a program-load port and run/halt control

It sits as the compute element under the course testbench, which loads a program, pulses start and waits for halted.

---
 rtl/proc_pkg.sv | 75 +++++++
 rtl/proc_alu.sv | 60 ++++++
 rtl/param_mc_proc.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the param_mc_proc multi-cycle core.
//   - opcode encoding (opcode_t)
//   - FSM state encoding (state_t + localparam constants)
//   - PSR bit positions, branch condition codes
//   - instruction field slice positions
//   - cc_true(): branch condition evaluation against the PSR
// Optional build macro consumed elsewhere: PROC_ILLEGAL_TRAP_EN.
package proc_pkg;

   typedef enum logic [3:0] {
      OP_NOP    = 4'd0,
      OP_LOAD   = 4'd1,
      OP_STORE  = 4'd2,
      OP_BRANCH = 4'd3,
      OP_XOR    = 4'd4,
      OP_ADD    = 4'd5,
      OP_ROTATE = 4'd6,
      OP_SHIFT  = 4'd7,
      OP_HALT   = 4'd8,
      OP_COMP   = 4'd9
   } opcode_t;

   // FSM state encoding kept as plain constants so legacy tools see bit patterns
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_FETCH     = 3'd1;
   localparam state_t ST_DECODE    = 3'd2;
   localparam state_t ST_EXECUTE   = 3'd3;
   localparam state_t ST_WRITEBACK = 3'd4;
   localparam state_t ST_HALTED    = 3'd5;

   // PSR layout {Z,N,E,P,C} = [4:0]
   localparam int PSR_Z = 4;
   localparam int PSR_N = 3;
   localparam int PSR_E = 2;
   localparam int PSR_P = 1;
   localparam int PSR_C = 0;

   localparam logic [3:0] CC_ALWAYS = 4'd0;
   localparam logic [3:0] CC_P      = 4'd1;
   localparam logic [3:0] CC_E      = 4'd2;
   localparam logic [3:0] CC_C      = 4'd3;
   localparam logic [3:0] CC_N      = 4'd4;
   localparam logic [3:0] CC_Z      = 4'd5;
   localparam logic [3:0] CC_NC     = 4'd6;
   localparam logic [3:0] CC_NN     = 4'd7;

   // Instruction fields
   localparam int F_OPC_HI = 31;
   localparam int F_OPC_LO = 28;
   localparam int F_CC_HI  = 27;
   localparam int F_CC_LO  = 24;
   localparam int F_SRCT   = 27;
   localparam int F_SRC_HI = 23;
   localparam int F_SRC_LO = 12;
   localparam int F_DST_HI = 11;
   localparam int F_DST_LO = 0;

   function automatic logic cc_true(input logic [3:0] cc, input logic [4:0] psr);
      logic t;
      case (cc)
         CC_ALWAYS: t = 1'b1;
         CC_P:      t = psr[PSR_P];
         CC_E:      t = psr[PSR_E];
         CC_C:      t = psr[PSR_C];
         CC_N:      t = psr[PSR_N];
         CC_Z:      t = psr[PSR_Z];
         CC_NC:     t = ~psr[PSR_C];
         CC_NN:     t = ~psr[PSR_N];
         default:   t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/proc_alu.sv
// proc_alu: combinational datapath for register-writing instructions.
// Ports:
//   op     in  4   opcode (opcode_t encoding)
//   dval   in  32  current reg[dst]
//   sval   in  32  source operand S (imm, reg or mem)
//   amt    in  12  two's-complement shift/rotate amount (src field)
//   result out 32  value written back to reg[dst]
//   carry  out 1   C flag (ADD carry-out, SHIFT last bit out, else 0)
// LOAD and any other opcode pass S through.
module proc_alu
   import proc_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] dval,
   input  logic [31:0] sval,
   input  logic [11:0] amt,
   output logic [31:0] result,
   output logic        carry
);

   logic [11:0] mag;
   logic [5:0]  sh;
   logic [4:0]  rk;
   logic [32:0] shl;
   logic [32:0] shr;
   logic [31:0] rotl;

   always_comb begin
      mag = amt[11] ? (~amt + 12'd1) : amt;
      // Anything beyond 33 positions already empties the 33-bit windows
      sh  = (mag > 12'd63) ? 6'd63 : mag[5:0];
      // Extra bit in each window catches the last bit shifted out
      shl = {1'b0, dval} << sh;
      shr = {dval, 1'b0} >> sh;
      // Rotate-right by k equals rotate-left by (-k mod 32), which is just
      // the low five bits of the two's-complement amount
      rk   = amt[4:0];
      rotl = (dval << rk) | (dval >> (6'd32 - {1'b0, rk}));

      result = sval;
      carry  = 1'b0;
      case (op)
         OP_XOR:    result = dval ^ sval;
         OP_ADD:    {carry, result} = {1'b0, dval} + {1'b0, sval};
         OP_ROTATE: result = rotl;
         OP_SHIFT: begin
            if (amt[11]) begin
               result = shr[32:1];
               carry  = shr[0];
            end else begin
               result = shl[31:0];
               carry  = shl[32];
            end
         end
         OP_COMP:   result = ~sval;
         default:   result = sval;
      endcase
   end

endmodule

// File: rtl/param_mc_proc.sv
// param_mc_proc: parametrised multi-cycle core (FETCH/DECODE/EXECUTE/
// WRITEBACK) with unified word memory, register file and 5-bit PSR.
// Parameters: MEM_DEPTH (words, pow2), NREGS (pow2), RESET_PC.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 run pulse, honoured in IDLE/HALTED
//   prog_we/addr/wdata    memory load port, honoured in IDLE/HALTED
//   dbg_raddr/dbg_rdata   combinational register-file peek
//   busy, halted          FETCH..WRITEBACK / HALTED
//   pc_o, psr_o, err      PC, {Z,N,E,P,C}, sticky illegal-opcode flag
// Build macro PROC_ILLEGAL_TRAP_EN: illegal opcodes halt on the faulting
// PC instead of executing as NOP.
module param_mc_proc
   import proc_pkg::*;
#(
   parameter int          MEM_DEPTH = 64,
   parameter int          NREGS     = 16,
   parameter logic [11:0] RESET_PC  = 12'h000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         prog_we,
   input  logic [$clog2(MEM_DEPTH)-1:0] prog_addr,
   input  logic [31:0]                  prog_wdata,
   input  logic [$clog2(NREGS)-1:0]     dbg_raddr,
   output logic [31:0]                  dbg_rdata,
   output logic                         busy,
   output logic                         halted,
   output logic [11:0]                  pc_o,
   output logic [4:0]                   psr_o,
   output logic                         err
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int RW = $clog2(NREGS);

   logic [31:0]            mem [MEM_DEPTH];
   logic [NREGS-1:0][31:0] regs;

   state_t      state;
   logic [11:0] pc;
   logic [4:0]  psr;
   logic        err_q;
   logic [31:0] ir;
   logic [31:0] op_s;   // S operand latched in DECODE
   logic [31:0] op_d;   // reg[dst] latched in DECODE

   // Instruction field views
   logic [3:0]    opc;
   logic [3:0]    cc;
   logic          src_imm;
   logic [11:0]   src_f;
   logic [11:0]   dst_f;
   logic [RW-1:0] src_r;
   logic [RW-1:0] dst_r;
   logic [AW-1:0] src_m;
   logic [AW-1:0] dst_m;

   assign opc     = ir[F_OPC_HI:F_OPC_LO];
   assign cc      = ir[F_CC_HI:F_CC_LO];
   assign src_imm = ir[F_SRCT];
   assign src_f   = ir[F_SRC_HI:F_SRC_LO];
   assign dst_f   = ir[F_DST_HI:F_DST_LO];
   assign src_r   = src_f[RW-1:0];
   assign dst_r   = dst_f[RW-1:0];
   assign src_m   = src_f[AW-1:0];
   assign dst_m   = dst_f[AW-1:0];

   logic        idle_like;
   logic [31:0] s_val;
   logic [31:0] alu_res;
   logic        alu_c;

   assign idle_like = (state == ST_IDLE) || (state == ST_HALTED);

   // S operand: immediate, else memory for LOAD, else register
   always_comb begin
      s_val = regs[src_r];
      if (src_imm)
         s_val = {20'h0, src_f};
      else if (opc == OP_LOAD)
         s_val = mem[src_m];
   end

   proc_alu u_alu (
      .op     (opc),
      .dval   (op_d),
      .sval   (op_s),
      .amt    (src_f),
      .result (alu_res),
      .carry  (alu_c)
   );

   // Control, register file and PSR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         pc    <= RESET_PC;
         psr   <= '0;
         err_q <= 1'b0;
         ir    <= '0;
         op_s  <= '0;
         op_d  <= '0;
         regs  <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_HALTED: begin
               if (start) begin
                  pc    <= RESET_PC;
                  psr   <= '0;
                  err_q <= 1'b0;
                  state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               ir    <= mem[pc[AW-1:0]];
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               op_s  <= s_val;
               op_d  <= regs[dst_r];
               state <= ST_EXECUTE;
            end
            ST_EXECUTE: begin
               case (opc)
                  OP_NOP, OP_STORE: begin
                     pc    <= pc + 12'd1;
                     state <= ST_FETCH;
                  end
                  OP_BRANCH: begin
                     pc    <= cc_true(cc, psr) ? dst_f : pc + 12'd1;
                     state <= ST_FETCH;
                  end
                  OP_HALT: state <= ST_HALTED;
                  OP_LOAD, OP_XOR, OP_ADD, OP_ROTATE, OP_SHIFT, OP_COMP:
                     state <= ST_WRITEBACK;
                  default: begin
                     err_q <= 1'b1;
`ifdef PROC_ILLEGAL_TRAP_EN
                     // PC left on the faulting word for post-mortem
                     state <= ST_HALTED;
`else
                     pc    <= pc + 12'd1;
                     state <= ST_FETCH;
`endif
                  end
               endcase
            end
            ST_WRITEBACK: begin
               regs[dst_r] <= alu_res;
               psr[PSR_Z]  <= (alu_res == 32'h0);
               psr[PSR_N]  <= alu_res[31];
               psr[PSR_E]  <= ~alu_res[0];
               psr[PSR_P]  <= ^alu_res;
               psr[PSR_C]  <= alu_c;
               pc          <= pc + 12'd1;
               state       <= ST_FETCH;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Memory has no reset. Stores are gated by state, which reset forces to
   // IDLE, so a STORE cut by reset never commits.
   always_ff @(posedge clk) begin
      if (idle_like && prog_we)
         mem[prog_addr] <= prog_wdata;
      else if (state == ST_EXECUTE && opc == OP_STORE)
         mem[dst_m] <= op_s;
   end

   assign dbg_rdata = regs[dbg_raddr];
   assign busy      = (state == ST_FETCH) || (state == ST_DECODE) ||
                      (state == ST_EXECUTE) || (state == ST_WRITEBACK);
   assign halted    = (state == ST_HALTED);
   assign pc_o      = pc;
   assign psr_o     = psr;
   assign err       = err_q;

endmodule
